count_ctrl: RTL and testbench

Sequencing controller for the 16-bit loadable up-counter datapath: owns the counter register and accepts CLEAR / LOAD / RUN / STOP commands over a valid/ready interface. For each command it drives the counter's clear, load and increment controls. After a counted run it reports completion over a second valid/ready handshake. It sits between the command-issuing logic and the combinational counter next-state datapath, which it instantiates.

---
 rtl/count_pkg.sv | 6 +
 rtl/count_next.sv | 17 +
 rtl/count_ctrl.sv | 71 +++++++
 tb/tb_count_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: command op encoding, controller state enum and default counter width
package count_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {OP_CLEAR = 2'd0, OP_LOAD = 2'd1, OP_RUN = 2'd2, OP_STOP = 2'd3} op_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/count_next.sv
// count_next: counter next value (in cnt, clear, load, load_data, inc; out nxt, wrap), priority clear > load > inc
module count_next #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             inc,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);
  always_comb begin
    nxt  = clear ? '0 : load ? load_data : inc ? cnt + WIDTH'(1) : cnt;
    wrap = ~clear & ~load & inc & (&cnt);
  end
endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: CLEAR/LOAD/RUN/STOP command sequencer owning the counter (cmd_* valid/ready in, cnt_q/busy/tc_pulse out, done_* valid/ready report)
module count_ctrl
  import count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_len,
  output logic [WIDTH-1:0] cnt_q,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] done_count
);
  state_t state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n, rem, dcnt;
  logic acc, idle_acc, run_acc, stop, inc, clr, ld, wrap, tc;
  always_comb begin
    cmd_ready = (state == S_IDLE) || (state == S_RUN && cmd_op == OP_STOP);
    acc       = cmd_valid & cmd_ready;
    idle_acc  = acc & (state == S_IDLE);
    clr       = idle_acc & (cmd_op == OP_CLEAR);
    ld        = idle_acc & (cmd_op == OP_LOAD);
    run_acc   = idle_acc & (cmd_op == OP_RUN);
    stop      = acc & (state == S_RUN);
    inc       = (state == S_RUN) & ~stop;
    state_n   = run_acc ? (cmd_len == '0 ? S_DONE : S_RUN) :
                (state == S_RUN && (stop || rem == WIDTH'(1))) ? S_DONE :
                (state == S_DONE && done_ready) ? S_IDLE : state;
  end
  count_next #(.WIDTH(WIDTH)) u_next (
    .cnt       (cnt),
    .clear     (clr),
    .load      (ld),
    .load_data (cmd_data),
    .inc       (inc),
    .nxt       (cnt_n),
    .wrap      (wrap)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      dcnt  <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tc    <= wrap;
      if (run_acc) begin
        rem  <= cmd_len;
        dcnt <= '0;
      end else if (inc) begin
        rem  <= rem - WIDTH'(1);
        dcnt <= dcnt + WIDTH'(1);
      end
    end
  end
  assign cnt_q      = cnt;
  assign busy       = (state == S_RUN);
  assign tc_pulse   = tc;
  assign done_valid = (state == S_DONE);
  assign done_count = dcnt;
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed stimulus with a behavioural reference model checked every cycle
module tb_count_ctrl;
  logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, done_ready = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_data = '0, cmd_len = '0;
  logic        cmd_ready, busy, tc_pulse, done_valid;
  logic [15:0] cnt_q, done_count;
  int tests = 0, fails = 0, tcs = 0;

  count_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .cnt_q(cnt_q), .busy(busy), .tc_pulse(tc_pulse),
    .done_valid(done_valid), .done_ready(done_ready), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: counter value, whether a run is in progress, steps left, steps done, pending report
  logic [15:0] m_cnt, m_left, m_dn;
  logic        m_busy, m_pend, m_tc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0; m_left <= '0; m_dn <= '0; m_busy <= 1'b0; m_pend <= 1'b0; m_tc <= 1'b0;
    end else begin
      m_tc <= 1'b0;
      if (m_pend) begin
        if (done_ready) m_pend <= 1'b0;
      end else if (m_busy) begin
        if (cmd_valid && cmd_op == 2'd3) begin
          m_busy <= 1'b0; m_pend <= 1'b1;
        end else begin
          m_tc   <= (m_cnt == 16'hFFFF);
          m_cnt  <= m_cnt + 16'd1;
          m_dn   <= m_dn + 16'd1;
          m_left <= m_left - 16'd1;
          if (m_left == 16'd1) begin m_busy <= 1'b0; m_pend <= 1'b1; end
        end
      end else if (cmd_valid) begin
        case (cmd_op)
          2'd0: m_cnt <= '0;
          2'd1: m_cnt <= cmd_data;
          2'd2: begin
            m_dn <= '0;
            if (cmd_len == '0) m_pend <= 1'b1;
            else begin m_left <= cmd_len; m_busy <= 1'b1; end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("cnt_q", cnt_q, m_cnt);
    chk("busy", busy, m_busy);
    chk("tc_pulse", tc_pulse, m_tc);
    chk("done_valid", done_valid, m_pend);
    chk("cmd_ready", cmd_ready, (!m_busy && !m_pend) || (m_busy && cmd_op == 2'd3));
    if (m_pend) chk("done_count", done_count, m_dn);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [15:0] l);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = l;
    #1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    chk("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_cnt", cnt_q, 0); chk("rst_busy", busy, 0); chk("rst_tc", tc_pulse, 0);
    chk("rst_dv", done_valid, 0); chk("rst_dc", done_count, 0); chk("rst_ready", cmd_ready, 1);
    tick(2); rst = 1'b0; tick();
    // reset in the middle of a run
    issue(2'd1, 16'h0010, 16'd0);
    issue(2'd2, 16'd0, 16'd8);
    tick(3);
    chk("midrun_cnt", cnt_q, 16'h0013);
    rst = 1'b1; #1;
    chk("rstrun_cnt", cnt_q, 0); chk("rstrun_busy", busy, 0); chk("rstrun_dv", done_valid, 0);
    tick(); rst = 1'b0;
    tick(12);
    chk("rstrun_noreport", done_valid, 0);
    // plain run of 5
    issue(2'd1, 16'h1234, 16'd0);
    issue(2'd2, 16'd0, 16'd5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("run5_cnt", cnt_q, 16'h1234 + i);
      chk("run5_dv", done_valid, i == 5);
    end
    chk("run5_dc", done_count, 5);
    handshake();
    chk("run5_idle_busy", busy, 0); chk("run5_idle_dv", done_valid, 0); chk("run5_idle_ready", cmd_ready, 1);
    // wrap through all-ones
    issue(2'd1, 16'hFFFE, 16'd0);
    issue(2'd2, 16'd0, 16'd3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("wrap_cnt", cnt_q, (16'hFFFE + i) & 16'hFFFF);
      chk("wrap_tc", tc_pulse, i == 2);
      if (tc_pulse) tcs++;
    end
    tick();
    chk("wrap_tc_count", tcs, 1);
    chk("wrap_dc", done_count, 3);
    handshake();
    // zero-length run
    issue(2'd2, 16'd0, 16'd0);
    chk("run0_dv", done_valid, 1); chk("run0_dc", done_count, 0); chk("run0_cnt", cnt_q, 16'h0001);
    handshake();
    // STOP mid-run with a stalled LOAD around it
    issue(2'd1, 16'h0000, 16'd0);
    issue(2'd2, 16'd0, 16'd10);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 16'hAAAA;
    tick(4);
    chk("stop_cnt_pre", cnt_q, 4); chk("stall_ready_run", cmd_ready, 0);
    cmd_op = 2'd3; #1;
    chk("stop_ready", cmd_ready, 1);
    tick();
    cmd_op = 2'd1;
    chk("stop_cnt", cnt_q, 4); chk("stop_dv", done_valid, 1); chk("stop_dc", done_count, 4);
    tick(2);
    chk("stall_cnt_done", cnt_q, 4); chk("stall_ready_done", cmd_ready, 0);
    handshake();
    chk("stall_ready_idle", cmd_ready, 1); chk("stall_cnt_idle", cnt_q, 4);
    tick();
    cmd_valid = 1'b0;
    chk("stall_load", cnt_q, 16'hAAAA);
    // STOP colliding with final increment, report held
    issue(2'd1, 16'h0100, 16'd0);
    issue(2'd2, 16'd0, 16'd6);
    tick(5);
    chk("last_cnt_pre", cnt_q, 16'h0105);
    cmd_valid = 1'b1; cmd_op = 2'd3;
    tick();
    cmd_valid = 1'b0;
    chk("last_dc", done_count, 5); chk("last_cnt", cnt_q, 16'h0105);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_dv", done_valid, 1); chk("hold_dc", done_count, 5);
    end
    handshake();
    chk("final_dv", done_valid, 0);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
